// File: rtl/gpu_bank_mem.sv
`default_nettype none
//============================================================================
// Module   : gpu_bank_mem
// Purpose  : Parametrised single-bank GPU memory with a pipelined core
//            read/write port, a hardware zero-fill (clear) engine and an
//            optional display (VGA) read port.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
// Parameters
//   DATA_W   word width in bits
//   ADDR_W   address width, depth = 2**ADDR_W
//   RD_LAT   core read latency in cycles (1..4)
//   BANK_ID  bank index (0..15), echoed on bank_id
// Ports
//   clock      rising-edge clock
//   reset      synchronous active-high reset
//   read       core read request
//   write      core write request
//   addr_in    core address
//   data_in    core write data
//   clear      start zero-fill of the whole bank
//   data_out   core read data (0 when no read completes)
//   finish     one pulse per accepted request, RD_LAT cycles later
//   busy       high while the clear engine runs
//   clear_done one-cycle pulse after the last address is cleared
//   bank_id    constant BANK_ID
//   addr_vga   display read address        (VGA_PORT_EN only)
//   data_vga   display read data, 1 cycle  (VGA_PORT_EN only)
// Build option
//   VGA_PORT_EN  define to build the display read port
//============================================================================
module gpu_bank_mem #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int RD_LAT  = 1,
    parameter int BANK_ID = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clear,
`ifdef VGA_PORT_EN
    input  logic [ADDR_W-1:0] addr_vga,
    output logic [DATA_W-1:0] data_vga,
`endif
    output logic [DATA_W-1:0] data_out,
    output logic              finish,
    output logic              busy,
    output logic              clear_done,
    output logic [3:0]        bank_id
);

    localparam int              c_DEPTH    = 2**ADDR_W;
    localparam logic [ADDR_W:0] c_CNT_LAST = {1'b0, {ADDR_W{1'b1}}};

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W:0]     r_cnt;
    logic                r_clear_done;
    logic [DATA_W-1:0]   r_mem [c_DEPTH];
    logic                r_pv  [RD_LAT];
    logic [DATA_W-1:0]   r_pd  [RD_LAT];

    logic                w_cnt_last;
    logic                w_accept;
    logic                w_clr_wr;
    logic [DATA_W-1:0]   w_rd_data;

    assign w_cnt_last = (r_cnt == c_CNT_LAST);
    // Requests are only taken in IDLE; anything arriving during a clear is dropped.
    assign w_accept   = (r_state == S_IDLE) && (read || write) && !reset;
    // A reset edge during a clear aborts it without writing that cycle's address.
    assign w_clr_wr   = (r_state == S_CLEAR) && !reset;
    // Read data is taken before any same-edge write lands (read-before-write).
    assign w_rd_data  = read ? r_mem[addr_in] : '0;

    //------------------------------------------------------------------
    // Clear FSM
    //------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (clear) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                // A second clear during a pass is ignored: only the counter ends it.
                if (w_cnt_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Counter sits at zero in IDLE so that entering CLEAR starts at address 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt        <= '0;
            r_clear_done <= 1'b0;
        end else begin
            r_clear_done <= (r_state == S_CLEAR) && w_cnt_last;
            if (r_state == S_IDLE) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    //------------------------------------------------------------------
    // Storage: core writes in IDLE, zero-fill in CLEAR (never both)
    //------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_accept && write) begin
            r_mem[addr_in] <= data_in;
        end else if (w_clr_wr) begin
            r_mem[r_cnt[ADDR_W-1:0]] <= '0;
        end
    end

    //------------------------------------------------------------------
    // Completion pipeline: stage 0 captures at the accepting edge, the
    // last stage drives finish/data_out. Non-read stages carry zero data.
    //------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_pv[i] <= 1'b0;
                r_pd[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_accept;
            r_pd[0] <= w_accept ? w_rd_data : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end

    assign finish     = r_pv[RD_LAT-1];
    assign data_out   = r_pd[RD_LAT-1];
    assign busy       = (r_state == S_CLEAR);
    assign clear_done = r_clear_done;
    assign bank_id    = 4'(BANK_ID);

`ifdef VGA_PORT_EN
    //------------------------------------------------------------------
    // Display port: free-running 1-cycle read, old data on write collision
    //------------------------------------------------------------------
    logic [DATA_W-1:0] r_data_vga;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_data_vga <= '0;
        end else begin
            r_data_vga <= r_mem[addr_vga];
        end
    end

    assign data_vga = r_data_vga;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gpu_bank_mem.sv
`default_nettype none
//============================================================================
// Module   : tb_gpu_bank_mem
// Purpose  : Self-checking bench for gpu_bank_mem. Two instances share the
//            same stimulus: one with RD_LAT=1, one with RD_LAT=3.
//            Build option VGA_PORT_EN enables the display-port checks.
// Revision : 1.0 - initial release
//============================================================================
module tb_gpu_bank_mem;

    logic       clock = 1'b0;
    logic       reset, read, write, clear;
    logic [7:0] addr_in, data_in, addr_vga;

    logic [7:0] dout1, dout3;
    logic       fin1, fin3, busy1, busy3, cd1, cd3;
    logic [3:0] bid1, bid3;
`ifdef VGA_PORT_EN
    logic [7:0] vga1, vga3;
`endif

    always #5 clock = ~clock;

    gpu_bank_mem #(.DATA_W(8), .ADDR_W(8), .RD_LAT(1), .BANK_ID(5)) u_dut1 (
        .clock(clock), .reset(reset), .read(read), .write(write),
        .addr_in(addr_in), .data_in(data_in), .clear(clear),
`ifdef VGA_PORT_EN
        .addr_vga(addr_vga), .data_vga(vga1),
`endif
        .data_out(dout1), .finish(fin1), .busy(busy1),
        .clear_done(cd1), .bank_id(bid1)
    );

    gpu_bank_mem #(.DATA_W(8), .ADDR_W(8), .RD_LAT(3), .BANK_ID(12)) u_dut3 (
        .clock(clock), .reset(reset), .read(read), .write(write),
        .addr_in(addr_in), .data_in(data_in), .clear(clear),
`ifdef VGA_PORT_EN
        .addr_vga(addr_vga), .data_vga(vga3),
`endif
        .data_out(dout3), .finish(fin3), .busy(busy3),
        .clear_done(cd3), .bank_id(bid3)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: memory image, per-request completion history
    // (index k = request accepted k edges ago), clear progress.
    logic [7:0] mmem [256];
    bit         hv   [4];
    logic [7:0] hd   [4];
    bit         e_busy;
    bit         e_cd;
    int         c_idx;
    logic [7:0] e_vga;

    // Drive one cycle of stimulus, advance the model at the edge, then
    // leave the caller 1 time unit after the edge to sample outputs.
    task automatic step(input bit rs, input bit rd, input bit wr,
                        input logic [7:0] a, input logic [7:0] d, input bit cl);
        bit         nv;
        logic [7:0] nd;
        @(negedge clock);
        reset = rs; read = rd; write = wr; addr_in = a; data_in = d; clear = cl;
        @(posedge clock);
        e_vga = rs ? 8'h00 : mmem[addr_vga];
        nv    = 1'b0;
        nd    = 8'h00;
        e_cd  = 1'b0;
        if (rs) begin
            e_busy = 1'b0;
            for (int i = 0; i < 4; i++) begin
                hv[i] = 1'b0;
                hd[i] = 8'h00;
            end
        end else begin
            if (e_busy) begin
                mmem[c_idx] = 8'h00;
                c_idx = c_idx + 1;
                if (c_idx == 256) begin
                    e_busy = 1'b0;
                    e_cd   = 1'b1;
                end
            end else begin
                if (rd || wr) begin
                    nv = 1'b1;
                    nd = rd ? mmem[a] : 8'h00;
                    if (wr) mmem[a] = d;
                end
                if (cl) begin
                    e_busy = 1'b1;
                    c_idx  = 0;
                end
            end
            for (int i = 3; i > 0; i--) begin
                hv[i] = hv[i-1];
                hd[i] = hd[i-1];
            end
            hv[0] = nv;
            hd[0] = nd;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 8'h00, 0);
    endtask

    task automatic test_reset;
        step(1, 0, 0, 8'h00, 8'h00, 0);
        step(1, 1, 1, 8'h33, 8'h44, 1);
        step(1, 0, 0, 8'h00, 8'h00, 0);
        n_total++;
        if ({fin1, dout1, busy1, cd1} !== 11'h0)
            $display("FAIL reset_dut1: got %h required 0", {fin1, dout1, busy1, cd1});
        else n_pass++;
        n_total++;
        if ({fin3, dout3, busy3, cd3} !== 11'h0)
            $display("FAIL reset_dut3: got %h required 0", {fin3, dout3, busy3, cd3});
        else n_pass++;
        n_total++;
        if (bid1 !== 4'd5) $display("FAIL bank_id1: got %0d required 5", bid1);
        else n_pass++;
        n_total++;
        if (bid3 !== 4'd12) $display("FAIL bank_id3: got %0d required 12", bid3);
        else n_pass++;
`ifdef VGA_PORT_EN
        n_total++;
        if (vga1 !== 8'h00) $display("FAIL reset_vga: got %h required 00", vga1);
        else n_pass++;
`endif
    endtask

    task automatic test_clear;
        int bc, cdp, cd_at;
        // First pass brings the uninitialised bank to a known image.
        step(0, 0, 0, 8'h00, 8'h00, 1);
        idle(258);
        for (int a = 0; a < 256; a++) step(0, 0, 1, 8'(a), 8'hFF, 0);
        step(0, 0, 0, 8'h00, 8'h00, 1);
        bc    = busy1 ? 1 : 0;
        cdp   = 0;
        cd_at = -1;
        for (int k = 0; k < 260; k++) begin
            if (k == 50) begin
                step(0, 0, 1, 8'hF0, 8'h5A, 1);
                n_total++;
                if (fin1 !== 1'b0) $display("FAIL clear_drop_write: finish got %b required 0", fin1);
                else n_pass++;
            end else begin
                step(0, 0, 0, 8'h00, 8'h00, 0);
            end
            if (busy1) bc++;
            if (cd1) begin
                cdp++;
                cd_at = k;
            end
        end
        n_total++;
        if (bc !== 256) $display("FAIL clear_busy_cycles: got %0d required 256", bc);
        else n_pass++;
        n_total++;
        if (cdp !== 1 || cd_at !== 255)
            $display("FAIL clear_done_pulse: got %0d pulses at %0d required 1 at 255", cdp, cd_at);
        else n_pass++;
        for (int a = 0; a < 256; a++) begin
            step(0, 1, 0, 8'(a), 8'h00, 0);
            n_total++;
            if ({fin1, dout1} !== 9'h100)
                $display("FAIL clear_readback[%0d]: got %h required 100", a, {fin1, dout1});
            else n_pass++;
        end
    endtask

    task automatic test_write_read;
        step(0, 0, 1, 8'h10, 8'hA5, 0);
        n_total++;
        if ({fin1, dout1} !== 9'h100)
            $display("FAIL wr_only_finish: got %h required 100", {fin1, dout1});
        else n_pass++;
        step(0, 1, 0, 8'h10, 8'h00, 0);
        n_total++;
        if ({fin1, dout1} !== 9'h1A5)
            $display("FAIL wr_rd_data: got %h required 1a5", {fin1, dout1});
        else n_pass++;
        step(0, 0, 0, 8'h00, 8'h00, 0);
        n_total++;
        if ({fin1, dout1} !== 9'h000)
            $display("FAIL wr_rd_idle: got %h required 000", {fin1, dout1});
        else n_pass++;
    endtask

    task automatic test_rw_same;
        step(0, 0, 1, 8'h20, 8'h07, 0);
        step(0, 1, 1, 8'h20, 8'h99, 0);
        n_total++;
        if ({fin1, dout1} !== 9'h107)
            $display("FAIL rw_old_value: got %h required 107", {fin1, dout1});
        else n_pass++;
        step(0, 1, 0, 8'h20, 8'h00, 0);
        n_total++;
        if ({fin1, dout1} !== 9'h199)
            $display("FAIL rw_new_value: got %h required 199", {fin1, dout1});
        else n_pass++;
    endtask

    task automatic test_latency;
        logic [8:0] tab [7];
        tab = '{9'h000, 9'h000, 9'h111, 9'h122, 9'h133, 9'h000, 9'h000};
        step(0, 0, 1, 8'h00, 8'h11, 0);
        step(0, 0, 1, 8'h01, 8'h22, 0);
        step(0, 0, 1, 8'h02, 8'h33, 0);
        idle(4);
        for (int j = 0; j < 7; j++) begin
            if (j < 3) step(0, 1, 0, 8'(j), 8'h00, 0);
            else       step(0, 0, 0, 8'h00, 8'h00, 0);
            n_total++;
            if ({fin3, dout3} !== tab[j])
                $display("FAIL lat3_cycle%0d: got %h required %h", j + 1, {fin3, dout3}, tab[j]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_inflight;
        int late;
        step(0, 1, 0, 8'h11, 8'h00, 0);
        step(1, 0, 0, 8'h00, 8'h00, 0);
        late = (fin1 ? 1 : 0) + (fin3 ? 1 : 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 8'h00, 8'h00, 0);
            late = late + (fin1 ? 1 : 0) + (fin3 ? 1 : 0);
        end
        n_total++;
        if (late !== 0) $display("FAIL inflight_after_reset: got %0d finishes required 0", late);
        else n_pass++;
    endtask

    task automatic test_reset_mid_clear;
        int cdp;
        for (int a = 0; a < 256; a++) step(0, 0, 1, 8'(a), 8'hFF, 0);
        step(0, 0, 0, 8'h00, 8'h00, 1);
        idle(99);
        step(1, 0, 0, 8'h00, 8'h00, 0);
        n_total++;
        if (busy1 !== 1'b0 || busy3 !== 1'b0)
            $display("FAIL abort_busy: got %b%b required 00", busy1, busy3);
        else n_pass++;
        cdp = cd1 ? 1 : 0;
        for (int k = 0; k < 260; k++) begin
            step(0, 0, 0, 8'h00, 8'h00, 0);
            if (cd1) cdp++;
        end
        n_total++;
        if (cdp !== 0) $display("FAIL abort_clear_done: got %0d pulses required 0", cdp);
        else n_pass++;
        step(0, 1, 0, 8'h00, 8'h00, 0);
        n_total++;
        if ({fin1, dout1} !== 9'h100)
            $display("FAIL abort_addr00: got %h required 100", {fin1, dout1});
        else n_pass++;
        step(0, 1, 0, 8'hC8, 8'h00, 0);
        n_total++;
        if ({fin1, dout1} !== 9'h1FF)
            $display("FAIL abort_addrC8: got %h required 1ff", {fin1, dout1});
        else n_pass++;
    endtask

`ifdef VGA_PORT_EN
    task automatic test_vga;
        logic [7:0] old;
        addr_vga = 8'h10;
        idle(1);
        old = mmem[8'h10];
        step(0, 0, 1, 8'h10, 8'h3C, 0);
        n_total++;
        if (vga1 !== old) $display("FAIL vga_collision: got %h required %h", vga1, old);
        else n_pass++;
        step(0, 0, 0, 8'h00, 8'h00, 0);
        n_total++;
        if (vga1 !== 8'h3C || vga3 !== 8'h3C)
            $display("FAIL vga_new: got %h/%h required 3c", vga1, vga3);
        else n_pass++;
        step(1, 0, 0, 8'h00, 8'h00, 0);
        n_total++;
        if (vga1 !== 8'h00) $display("FAIL vga_reset: got %h required 00", vga1);
        else n_pass++;
    endtask
`endif

    task automatic test_random;
        logic [21:0] got, exp;
        bit rs, rd, wr, cl;
        for (int k = 0; k < 600; k++) begin
            rs = ($urandom_range(0, 59) == 0);
            rd = $urandom_range(0, 1) == 1;
            wr = $urandom_range(0, 2) == 0;
            cl = ($urandom_range(0, 199) == 0);
            addr_vga = 8'($urandom_range(0, 15));
            step(rs, rd, wr, 8'($urandom_range(0, 15)), 8'($urandom), cl);
            got = {fin1, dout1, fin3, dout3, busy1, cd1, busy3, cd3};
            exp = {hv[0], hd[0], hv[2], hd[2], e_busy, e_cd, e_busy, e_cd};
            n_total++;
            if (got !== exp) $display("FAIL random_%0d: got %h required %h", k, got, exp);
            else n_pass++;
`ifdef VGA_PORT_EN
            n_total++;
            if (vga1 !== e_vga || vga3 !== e_vga)
                $display("FAIL random_vga_%0d: got %h/%h required %h", k, vga1, vga3, e_vga);
            else n_pass++;
`endif
        end
    endtask

    initial begin
        reset = 1'b1; read = 1'b0; write = 1'b0; clear = 1'b0;
        addr_in = 8'h00; data_in = 8'h00; addr_vga = 8'h00;
        e_busy = 1'b0; e_cd = 1'b0; c_idx = 0; e_vga = 8'h00;
        for (int i = 0; i < 256; i++) mmem[i] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            hv[i] = 1'b0;
            hd[i] = 8'h00;
        end
        test_reset;
        test_clear;
        test_write_read;
        test_rw_same;
        test_latency;
        test_reset_inflight;
        test_reset_mid_clear;
`ifdef VGA_PORT_EN
        test_vga;
`endif
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
